lsq_param: RTL

- Parametrised in-order load/store queue, successor to the single-config LSB.
- Sits between issue, ROB and memory arbiter.
- Snoops CDB_N broadcast channels for operand wakeup.
- Serialises memory ops from the head; stores and IO loads wait for ROB commit.
- Preserves committed-but-unwritten stores across a branch flush.

---
 rtl/lsq_pkg.sv | 45 ++++
 rtl/lsq_wakeup.sv | 50 +++++
 rtl/lsq_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: op codes, head FSM states, entry and
// memory-request records, plus per-op size and load-extension helpers.
package lsq_pkg;
  typedef enum logic [2:0] {
    LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
    LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7
  } op_e;

  typedef enum logic [2:0] {IDLE, LD_REQ, ST_REQ, WAIT, ST_WAIT, IO_WAIT} state_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] imm;
  } ent_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic is_load(op_e op);
    return op <= LHU;
  endfunction

  // Size encoded as bytes-1.
  function automatic logic [1:0] op_size(op_e op);
    case (op)
      LB, LBU, SB: return 2'd0;
      LH, LHU, SH: return 2'd1;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(op_e op, logic [31:0] d);
    case (op)
      LB:      return {{24{d[7]}}, d[7:0]};
      LH:      return {{16{d[15]}}, d[15:0]};
      LBU:     return {24'd0, d[7:0]};
      LHU:     return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/lsq_wakeup.sv
// One operand tag/value slot of a queue entry; captures from the CDB at push
// and wakes up on later broadcasts. Lowest channel index wins a multi-hit.
module lsq_wakeup #(
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   active,
  input  logic                   load,
  input  logic [ROB_W-1:0]       load_q,
  input  logic [31:0]            load_v,
  input  logic [CDB_N-1:0]       cdb_en,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob,
  input  logic [CDB_N*32-1:0]    cdb_data,
  output logic [ROB_W-1:0]       q,
  output logic [31:0]            v
);
  logic [ROB_W-1:0] probe;
  logic             hit;
  logic [31:0]      hit_data;

  always_comb begin
    probe    = load ? load_q : q;
    hit      = 1'b0;
    hit_data = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (cdb_en[c] && probe != '0 && cdb_rob[c*ROB_W +: ROB_W] == probe) begin
        hit      = 1'b1;
        hit_data = cdb_data[c*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q <= '0;
      v <= '0;
    end else if (rdy_in) begin
      if (load) begin
        q <= hit ? '0 : load_q;
        v <= hit ? hit_data : load_v;
      end else if (active && hit) begin
        q <= '0;
        v <= hit_data;
      end
    end
  end
endmodule

// File: rtl/lsq_param.sv
// Parametrised in-order load/store queue. Optional misaligned-access trap is
// enabled by defining LSQ_MISALIGN_CHK_EN (adds exc_out).
module lsq_param
  import lsq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ROB_W  = 4,
  parameter int CDB_N  = 2,
  parameter int IO_BIT = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   disp_en_in,
  input  logic [2:0]             disp_op_in,
  input  logic [ROB_W-1:0]       disp_rob_in,
  input  logic [31:0]            disp_imm_in,
  input  logic [ROB_W-1:0]       disp_q1_in,
  input  logic [ROB_W-1:0]       disp_q2_in,
  input  logic [31:0]            disp_v1_in,
  input  logic [31:0]            disp_v2_in,
  input  logic [CDB_N-1:0]       cdb_en_in,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob_in,
  input  logic [CDB_N*32-1:0]    cdb_data_in,
  output logic                   full_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   mem_req_out,
  output logic                   mem_we_out,
  output logic [31:0]            mem_addr_out,
  output logic [1:0]             mem_size_out,
  output logic [31:0]            mem_wdata_out,
  input  logic                   mem_gnt_in,
  input  logic                   mem_done_in,
  input  logic [31:0]            mem_rdata_in,
  output logic                   res_en_out,
  output logic [ROB_W-1:0]       res_rob_out,
  output logic [31:0]            res_data_out,
  output logic                   st_rdy_en_out,
  output logic                   io_ld_en_out,
  output logic [ROB_W-1:0]       head_rob_out,
  input  logic                   commit_en_in,
  input  logic                   clear_in
`ifdef LSQ_MISALIGN_CHK_EN
  , output logic                 exc_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e                        state;
  logic [AW-1:0]                 head, tail;
  logic [DEPTH-1:0]              vld, com, com_eff;
  ent_t [DEPTH-1:0]              ent;
  logic [DEPTH-1:0][ROB_W-1:0]   rob, q1, q2;
  logic [DEPTH-1:0][31:0]        v1, v2;
  mem_req_t                      req_q, h_req;
  logic                          push, pop, commit_ok, fsm_run, h_rdy, h_ld, h_io, h_mis;
  logic [31:0]                   h_addr;
  logic [CW-1:0]                 n_com;
  op_e                           h_op;

  assign full_out      = (count_out == CW'(DEPTH));
  assign push          = disp_en_in && !full_out && !clear_in;
  assign commit_ok     = commit_en_in && (state == ST_WAIT || state == IO_WAIT);
  assign h_op          = ent[head].op;
  assign h_addr        = v1[head] + ent[head].imm;
  assign h_ld          = is_load(h_op);
  assign h_io          = (h_addr[IO_BIT:IO_BIT-1] == 2'b11);
  assign h_rdy         = vld[head] && q1[head] == '0 && q2[head] == '0;
  assign h_req         = '{we: !h_ld, addr: h_addr, size: op_size(h_op), wdata: v2[head]};
  assign mem_we_out    = req_q.we;
  assign mem_addr_out  = req_q.addr;
  assign mem_size_out  = req_q.size;
  assign mem_wdata_out = req_q.wdata;
`ifdef LSQ_MISALIGN_CHK_EN
  assign h_mis = (op_size(h_op) == 2'd1 && h_addr[0]) ||
                 (op_size(h_op) == 2'd3 && h_addr[1:0] != 2'b00);
`else
  assign h_mis = 1'b0;
`endif
  // A flush only spares the head if it is (or is just now being) committed.
  assign fsm_run = !clear_in || com_eff[head];
  assign pop     = fsm_run && ((state == WAIT && mem_done_in) ||
                               (state == IDLE && h_rdy && h_mis));

  always_comb begin
    com_eff = com;
    if (commit_ok) com_eff[head] = 1'b1;
    n_com = '0;
    for (int i = 0; i < DEPTH; i++) n_com += CW'(com_eff[i]);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic ld;
    assign ld = push && (tail == AW'(i));
    lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_op1 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .active(vld[i]),
      .load(ld), .load_q(disp_q1_in), .load_v(disp_v1_in),
      .cdb_en(cdb_en_in), .cdb_rob(cdb_rob_in), .cdb_data(cdb_data_in),
      .q(q1[i]), .v(v1[i]));
    lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_op2 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .active(vld[i]),
      .load(ld), .load_q(disp_q2_in), .load_v(disp_v2_in),
      .cdb_en(cdb_en_in), .cdb_rob(cdb_rob_in), .cdb_data(cdb_data_in),
      .q(q2[i]), .v(v2[i]));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count_out     <= '0;
      vld           <= '0;
      com           <= '0;
      ent           <= '0;
      rob           <= '0;
      req_q         <= '0;
      mem_req_out   <= 1'b0;
      res_en_out    <= 1'b0;
      res_rob_out   <= '0;
      res_data_out  <= '0;
      st_rdy_en_out <= 1'b0;
      io_ld_en_out  <= 1'b0;
      head_rob_out  <= '0;
`ifdef LSQ_MISALIGN_CHK_EN
      exc_out       <= 1'b0;
`endif
    end else begin
      // Pulses drop even while stalled so none can repeat for the same entry.
      res_en_out    <= 1'b0;
      st_rdy_en_out <= 1'b0;
      io_ld_en_out  <= 1'b0;
`ifdef LSQ_MISALIGN_CHK_EN
      exc_out       <= 1'b0;
`endif
      if (rdy_in) begin
        if (push) begin
          ent[tail] <= '{op: op_e'(disp_op_in), imm: disp_imm_in};
          rob[tail] <= disp_rob_in;
        end
        if (clear_in) begin
          vld       <= com_eff;
          com       <= com_eff;
          tail      <= head + n_com[AW-1:0];
          count_out <= n_com - CW'(pop);
        end else begin
          com <= com_eff;
          if (push) begin
            vld[tail] <= 1'b1;
            tail      <= tail + AW'(1);
          end
          count_out <= count_out + CW'(push) - CW'(pop);
        end
        if (pop) begin
          vld[head] <= 1'b0;
          com[head] <= 1'b0;
          head      <= head + AW'(1);
        end

        if (!fsm_run) begin
          state       <= IDLE;
          mem_req_out <= 1'b0;
          req_q.we    <= 1'b0;
        end else begin
          case (state)
            IDLE: if (h_rdy) begin
`ifdef LSQ_MISALIGN_CHK_EN
              if (h_mis) begin
                res_en_out   <= 1'b1;
                res_rob_out  <= rob[head];
                res_data_out <= h_addr;
                exc_out      <= 1'b1;
              end else
`endif
              if (h_ld && !h_io) begin
                state       <= LD_REQ;
                mem_req_out <= 1'b1;
                req_q       <= h_req;
              end else begin
                state         <= h_ld ? IO_WAIT : ST_WAIT;
                io_ld_en_out  <= h_ld;
                st_rdy_en_out <= !h_ld;
                head_rob_out  <= rob[head];
              end
            end
            ST_WAIT, IO_WAIT: if (commit_en_in) begin
              state       <= (state == ST_WAIT) ? ST_REQ : LD_REQ;
              mem_req_out <= 1'b1;
              req_q       <= h_req;
            end
            LD_REQ, ST_REQ: if (mem_gnt_in) begin
              mem_req_out <= 1'b0;
              state       <= WAIT;
            end
            WAIT: if (mem_done_in) begin
              if (h_ld) begin
                res_en_out   <= 1'b1;
                res_rob_out  <= rob[head];
                res_data_out <= load_ext(h_op, mem_rdata_in);
              end
              req_q.we <= 1'b0;
              state    <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule
